// File: rtl/addsub_pkg.sv
// Shared FSM encoding and mode constants for the multicycle adder/subtractor.
// No logic; imported by addsub_multicycle.
package addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder, zero latency, no flow control.
// cin_msb exposes the carry entering the top bit for signed-overflow detection.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cin_msb
);

  logic w_c;

  always_comb begin
    w_c     = cin;
    s       = '0;
    cin_msb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) cin_msb = w_c;
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/addsub_multicycle.sv
// WIDTH-bit add/sub processed CHUNK bits per cycle; result valid K=WIDTH/CHUNK cycles after accept.
// Single request in flight: in_ready only in IDLE; result held in DONE until out_ready.
module addsub_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  import addsub_pkg::*;

  localparam int K  = WIDTH / CHUNK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_sub;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IW-1:0]    r_idx;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_last;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < K; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_last = (r_idx == IW'(K - 1));

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (w_a_chunk),
    .b       (w_b_chunk),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_cout),
    .cin_msb (w_cin_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= MODE_ADD;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1: invert b here, the +1 enters as the initial carry.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int k = 0; k < K; k++) begin
            if (r_idx == IW'(k)) r_sum[k*CHUNK +: CHUNK] <= w_s;
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout  <= w_cout ^ r_sub;
            r_ovf   <= w_cin_msb ^ w_cout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign overflow  = r_ovf;
  // Gated so that zero reads 0 out of reset even though the cleared sum is all zeros.
  assign zero      = out_valid && (r_sum == '0);
  assign negative  = r_sum[WIDTH-1];

endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: 32/8 and 8/8 instances against an arithmetic reference model.
module tb_addsub_multicycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        tb_valid = 1'b0;
  logic        tb_ready = 1'b0;
  logic        tb_sub   = 1'b0;
  logic        sel8     = 1'b0;
  logic [31:0] tb_a     = '0;
  logic [31:0] tb_b     = '0;

  logic        rdy32, vld32, c32, ov32, z32, n32;
  logic [31:0] sum32;
  logic        rdy8, vld8, c8, ov8, z8, n8;
  logic [7:0]  sum8;

  logic        o_rdy, o_vld, o_c, o_ov, o_z, o_n;
  logic [31:0] o_sum;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(tb_valid & ~sel8), .in_ready(rdy32),
    .a(tb_a), .b(tb_b), .sub(tb_sub),
    .out_valid(vld32), .out_ready(tb_ready & ~sel8),
    .sum(sum32), .c_out(c32), .overflow(ov32), .zero(z32), .negative(n32)
  );

  addsub_multicycle #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(tb_valid & sel8), .in_ready(rdy8),
    .a(tb_a[7:0]), .b(tb_b[7:0]), .sub(tb_sub),
    .out_valid(vld8), .out_ready(tb_ready & sel8),
    .sum(sum8), .c_out(c8), .overflow(ov8), .zero(z8), .negative(n8)
  );

  always_comb begin
    o_rdy = sel8 ? rdy8 : rdy32;
    o_vld = sel8 ? vld8 : vld32;
    o_sum = sel8 ? {24'd0, sum8} : sum32;
    o_c   = sel8 ? c8   : c32;
    o_ov  = sel8 ? ov8  : ov32;
    o_z   = sel8 ? z8   : z32;
    o_n   = sel8 ? n8   : n32;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain w-bit arithmetic, carry = unsigned carry-out (add) or borrow (sub).
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic s,
                       output logic [31:0] rs, output logic rc, output logic rov,
                       output logic rz, output logic rn);
    logic [63:0] m, aa, bb, full;
    logic sa, sb, ss;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, av} & m;
    bb = {32'd0, bv} & m;
    if (!s) begin
      full = aa + bb;
      rc   = full[w];
    end else begin
      full = aa - bb;
      rc   = (aa < bb);
    end
    full = full & m;
    rs   = full[31:0];
    sa   = aa[w-1];
    sb   = bb[w-1];
    ss   = full[w-1];
    rov  = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    rz   = (full == 64'd0);
    rn   = ss;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic op(input bit use8, input logic [31:0] av, input logic [31:0] bv,
                    input logic s, input int hold);
    int k, w, lat;
    logic [31:0] es;
    logic ec, eov, ez, en;
    k = use8 ? 1 : 4;
    w = use8 ? 8 : 32;
    model(w, av, bv, s, es, ec, eov, ez, en);
    @(negedge clk);
    sel8 = use8;
    #1;
    chk("idle_in_ready", o_rdy, 1);
    tb_valid = 1'b1;
    tb_a = av;
    tb_b = bv;
    tb_sub = s;
    @(negedge clk);
    tb_valid = 1'b0;
    tb_a = $urandom;
    tb_b = $urandom;
    tb_sub = 1'($urandom);
    lat = 0;
    while (!o_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, k);
    chk("sum", o_sum, es);
    chk("c_out", o_c, ec);
    chk("overflow", o_ov, eov);
    chk("zero", o_z, ez);
    chk("negative", o_n, en);
    chk("done_in_ready", o_rdy, 0);
    tb_valid = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      tb_a = $urandom;
      tb_b = $urandom;
      chk("hold_valid", o_vld, 1);
      chk("hold_in_ready", o_rdy, 0);
      chk("hold_sum", o_sum, es);
      chk("hold_flags", {o_c, o_ov, o_z, o_n}, {ec, eov, ez, en});
    end
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    chk("post_hs_in_ready", o_rdy, 1);
    chk("post_hs_out_valid", o_vld, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      sel8 = v[0];
      #1;
      chk("rst_in_ready", o_rdy, 1);
      chk("rst_out_valid", o_vld, 0);
      chk("rst_sum", o_sum, 0);
      chk("rst_flags", {o_c, o_ov, o_z, o_n}, 4'b0000);
    end
    rst = 1'b0;

    op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    op(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 3);
    op(1, 32'h0000_0080, 32'h0000_0001, 1'b1, 0);
    op(1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 2);

    // Reset during the second BUSY cycle.
    @(negedge clk);
    sel8 = 1'b0;
    tb_valid = 1'b1;
    tb_a = 32'h0F0F_0F0F;
    tb_b = 32'h0101_0101;
    tb_sub = 1'b0;
    @(negedge clk);
    tb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", o_rdy, 1);
    chk("midrst_out_valid", o_vld, 0);
    chk("midrst_sum", o_sum, 0);
    chk("midrst_flags", {o_c, o_ov, o_z, o_n}, 4'b0000);
    rst = 1'b0;
    op(0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    tb_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    tb_valid = 1'b0;
    rst = 1'b0;
    chk("rstpri_in_ready", o_rdy, 1);
    repeat (5) @(negedge clk);
    chk("rstpri_out_valid", o_vld, 0);

    for (int i = 0; i < 40; i++)
      op(0, rnd_opnd(), rnd_opnd(), 1'($urandom), int'($urandom % 3));
    for (int i = 0; i < 20; i++)
      op(1, {24'd0, 8'($urandom)}, {24'd0, 8'($urandom)}, 1'($urandom), int'($urandom % 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_multicycle.md
ADDSUB_MULTICYCLE -- requirements
Module: addsub_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK (K = WIDTH/CHUNK).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  minuend/augend.
REQ-008 SHALL have port b  input  WIDTH  subtrahend/addend.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port c_out  output  1  carry (add) / borrow (sub).
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-015 SHALL have ports zero, negative  output  1 each  sum==0, sum[WIDTH-1].

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: in_ready=1; on in_valid SHALL register a, b XOR {WIDTH{sub}}, sub; set carry=sub, chunk index=0; go BUSY.
REQ-018 BUSY: each cycle SHALL add chunk[index] of a and inverted-b with running carry, write result chunk into sum register, update carry, increment index.
REQ-019 On the cycle processing chunk K-1 SHALL capture carry-into-MSB and final carry, then go DONE.
REQ-020 Latency SHALL be exactly K cycles from accept edge to out_valid=1; K=1 is legal (single BUSY cycle).
REQ-021 DONE: out_valid=1, in_ready=0; sum and flags SHALL hold stable until out_ready=1, then go IDLE.
REQ-022 c_out SHALL equal final carry XOR sub (1 = borrow on subtract).
REQ-023 overflow SHALL equal carry-into-MSB XOR final carry.
REQ-024 zero and negative SHALL be derived from the registered sum, valid whenever out_valid=1.
REQ-025 in_valid SHALL be ignored outside IDLE; no request queueing; inputs need not stay stable after accept.
REQ-026 sum/flags SHALL not change while out_valid=1; outside DONE their values are don't-care except after reset.

Reset
REQ-027 rst=1 SHALL, at the next clock edge and from any state (including mid-BUSY), force IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0, zero=0, negative=0, index=0, carry=0.
REQ-028 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-029 State encoding and the mode constants (ADD=0, SUB=1) SHALL live in shared package addsub_pkg.
REQ-030 Combinational CHUNK-bit ripple add SHALL be sub-module addsub_chunk (inputs a, b, cin; outputs s, cout, cin_msb).
REQ-031 Index counter width SHALL be clog2(K), minimum 1.

Verification
REQ-032 WIDTH=32, CHUNK=8: add 0x7FFFFFFF+0x00000001 -> sum 0x80000000, overflow=1, c_out=0, negative=1, out_valid 4 cycles after accept.
REQ-033 sub 0x00000005-0x00000007 -> sum 0xFFFFFFFE, c_out=1, overflow=0, negative=1, zero=0.
REQ-034 add 0xFFFFFFFF+0x00000001 -> sum 0x00000000, c_out=1, zero=1, overflow=0.
REQ-035 out_ready held 0 for 3 cycles in DONE with in_valid=1 -> sum/flags stable, in_ready=0, no new accept; accept occurs cycle after out_ready=1 handshake.
REQ-036 rst asserted on 2nd BUSY cycle -> next edge IDLE, in_ready=1, out_valid=0, sum=0; subsequent request completes correctly.
REQ-037 WIDTH=8, CHUNK=8: sub 0x80-0x01 -> sum 0x7F, overflow=1, c_out=0, out_valid 1 cycle after accept.
